id_encoder: RTL and testbench



---
 rtl/id_encoder.sv | 136 +++++++++++++
 tb/tb_id_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_encoder.sv
// id_encoder: turns a (prefix letter, 16-bit value) pair into an ASCII identifier token.
// Binary-to-BCD conversion is sequential (double-dabble), then one character is emitted per handshake.
module id_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_prefix,
  input  logic [15:0] i_value,
  input  logic        i_ready,
  output logic [7:0]  o_char,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CONV     = 2'd1;
  localparam logic [1:0] S_EMIT_LET = 2'd2;
  localparam logic [1:0] S_EMIT_DIG = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_prefix;
  logic [15:0] r_bin;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [2:0]  r_ptr;
  logic [7:0]  r_char;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic [19:0] w_bcdAdj;
  logic [19:0] w_bcdNext;
  logic [15:0] w_binNext;
  logic [2:0]  w_firstIdx;
  logic [4:0]  w_pfxSat;
  logic [7:0]  w_letter;
  logic        w_fire;

  function automatic logic [7:0] digitAt(input logic [19:0] bcd, input logic [2:0] p);
    return 8'h30 + {4'h0, bcd[{p, 2'b00} +: 4]};
  endfunction

  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_bcdAdj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_bcdNext = {w_bcdAdj[18:0], r_bin[15]};
  assign w_binNext = {r_bin[14:0], 1'b0};

  // Highest nonzero digit wins; an all-zero value leaves index 0 so a lone '0' is sent.
  always_comb begin
    w_firstIdx = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (w_bcdNext[i*4 +: 4] != 4'd0) begin
        w_firstIdx = 3'(i);
      end
    end
  end

  assign w_pfxSat = (r_prefix > 5'd25) ? 5'd25 : r_prefix;
  assign w_letter = 8'h61 + {3'b000, w_pfxSat};
  assign w_fire   = r_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_prefix <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_char   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_prefix <= i_prefix;
            r_bin    <= i_value;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= w_bcdNext;
          r_bin <= w_binNext;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_ptr   <= w_firstIdx;
            r_char  <= w_letter;
            r_valid <= 1'b1;
            r_state <= S_EMIT_LET;
          end
        end
        S_EMIT_LET: begin
          if (w_fire) begin
            r_char  <= digitAt(r_bcd, r_ptr);
            r_state <= S_EMIT_DIG;
          end
        end
        S_EMIT_DIG: begin
          if (w_fire) begin
            if (r_ptr == 3'd0) begin
              r_char  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ptr  <= r_ptr - 3'd1;
              r_char <= digitAt(r_bcd, r_ptr - 3'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_char  = r_char;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_id_encoder.sv
// Self-checking bench for id_encoder: directed and random tokens against a decimal-arithmetic model.
module tb_id_encoder;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [4:0]  prefix;
  logic [15:0] value;
  logic        ready;
  logic [7:0]  charOut;
  logic        valid;
  logic        busy;
  logic        done;

  int testsRun;
  int testsFailed;

  id_encoder dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_start  (start),
    .i_prefix (prefix),
    .i_value  (value),
    .i_ready  (ready),
    .o_char   (charOut),
    .o_valid  (valid),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Model: letter then the decimal digits found by repeated division by ten.
  function automatic void buildToken(input logic [4:0] p, input logic [15:0] v, ref logic [7:0] tok[$]);
    int unsigned n;
    int unsigned letterIdx;
    tok.delete();
    letterIdx = (p > 25) ? 25 : p;
    n = v;
    if (n == 0) tok.push_front(8'h30);
    while (n > 0) begin
      tok.push_front(8'(8'h30 + n % 10));
      n = n / 10;
    end
    tok.push_front(8'(8'h61 + letterIdx));
  endfunction

  // readyMode: 0 = always ready, 1 = random, 2 = 0,0,1,0,1,1 then ready.
  // abortAfter: nonzero pulls reset once that many characters have transferred.
  task automatic applyStimulus(input logic [4:0] p, input logic [15:0] v, input int readyMode,
                               input bit interfere, input int abortAfter);
    logic [7:0] expTok[$];
    logic [7:0] gotTok[$];
    int         doneCount = 0;
    int         doneCycle = 0;
    int         emitIdx = 0;
    int         postDone = 0;
    bit         prevStall = 1'b0;
    logic [7:0] heldChar = 8'h00;
    bit         finished = 1'b0;
    bit         patt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int         cyc;

    buildToken(p, v, expTok);
    @(negedge clk);
    start  = 1'b1;
    prefix = p;
    value  = v;
    @(posedge clk);
    #1;
    checkOutput("busy_after_start", busy, 1);

    for (cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (interfere && (cyc == 3 || cyc == 17)) begin
        start  = 1'b1;
        prefix = 5'(p + 5'd3);
        value  = v ^ 16'h5A5A;
      end
      if (!valid) ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (readyMode == 0) ready = 1'b1;
      else if (readyMode == 1) ready = 1'($urandom_range(0, 1));
      else ready = (emitIdx < 6) ? patt[emitIdx] : 1'b1;

      if (cyc == 16) checkOutput("valid_low_before_letter", valid, 0);
      if (cyc == 17) checkOutput("valid_rise_letter", valid, 1);
      if (prevStall) checkOutput("hold_stable", {valid, charOut}, {1'b1, heldChar});
      if (!valid) checkOutput("char_zero_idle", charOut, 0);
      if (done) begin
        doneCount++;
        doneCycle = cyc;
        checkOutput("done_valid_low", valid, 0);
        checkOutput("done_busy_low", busy, 0);
      end

      if (abortAfter != 0 && gotTok.size() == abortAfter) begin
        ready = 1'b0;
        rstN  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_outputs", {charOut, valid, busy, done}, 0);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (done || valid || busy) checkOutput("abort_quiet", {valid, busy, done}, 0);
        end
        checkOutput("abort_no_done", doneCount, 0);
        return;
      end

      prevStall = valid && !ready;
      heldChar  = charOut;
      if (valid) begin
        emitIdx++;
        if (ready) gotTok.push_back(charOut);
      end
      if (doneCount > 0) begin
        postDone++;
        if (postDone > 6) finished = 1'b1;
      end
    end

    if (!finished) checkOutput("timeout", 0, 1);
    checkOutput("token_len", gotTok.size(), expTok.size());
    for (int i = 0; i < expTok.size() && i < gotTok.size(); i++) begin
      checkOutput($sformatf("char%0d_p%0d_v%0d", i, p, v), gotTok[i], expTok[i]);
    end
    checkOutput("done_count", doneCount, 1);
    if (readyMode == 0) checkOutput("done_latency", doneCycle, 17 + expTok.size());
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstN   = 1'b0;
    start  = 1'b0;
    prefix = '0;
    value  = '0;
    ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {charOut, valid, busy, done}, 0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(5'd0, 16'd0, 0, 1'b0, 0);
    applyStimulus(5'd25, 16'd65535, 0, 1'b0, 0);
    applyStimulus(5'd7, 16'd1005, 0, 1'b0, 0);
    applyStimulus(5'd31, 16'd40, 0, 1'b0, 0);
    applyStimulus(5'd2, 16'd12, 2, 1'b0, 0);
    applyStimulus(5'd4, 16'd10000, 0, 1'b1, 0);
    applyStimulus(5'd25, 16'd65535, 0, 1'b0, 2);
    applyStimulus(5'd19, 16'd907, 0, 1'b0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [15:0] rv;
      case ($urandom_range(0, 3))
        0: rv = 16'($urandom_range(0, 9));
        1: rv = 16'($urandom_range(0, 999));
        default: rv = 16'($urandom);
      endcase
      applyStimulus(5'($urandom_range(0, 31)), rv, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
